// File: rtl/regalu_sched_pkg.sv
// regalu_pkg: shared definitions for the register-file/ALU scheduler.
//   - ALU opcode constants (ADD..ARSH, NOP)
//   - instruction class constants (register form, shift form)
//   - scheduler state enum and decoded-instruction struct
//   - map_func(): 4-bit function/class field -> ALU opcode
package regalu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_CMP  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0110;
  localparam logic [3:0] OP_LSH  = 4'b0111;
  localparam logic [3:0] OP_ARSH = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [3:0] CLS_REG   = 4'b0000;
  localparam logic [3:0] CLS_SHIFT = 4'b1000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SETTLE = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_e;

  // rsrc_vld / imm_vld mark which fields this instruction updates; the
  // other datapath fields keep their previous value.
  typedef struct packed {
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic        rsrc_vld;
    logic [15:0] imm;
    logic        imm_vld;
    logic        imm_s;
    logic [3:0]  opcode;
  } dec_t;

  // Shared by the register-form function field and the immediate-form class.
  function automatic logic [3:0] map_func(input logic [3:0] f);
    case (f)
      4'b0101: map_func = OP_ADD;
      4'b1001: map_func = OP_SUB;
      4'b1011: map_func = OP_CMP;
      4'b0001: map_func = OP_AND;
      4'b0010: map_func = OP_OR;
      4'b0011: map_func = OP_XOR;
      default: map_func = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/regalu_sched_if.sv
// regalu_sched_if: source handshake and datapath bus of the scheduler.
//   Source side : Req0/1, Instr0/1 in; Gnt0/1, Done0/1, Result, ResultFlags out
//   Datapath    : RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode, En out;
//                 RdestOut, Flags in
//   slave  modport: the scheduler
//   master modport: the sources / datapath model driving it
interface regalu_sched_if;
  logic        Req0, Req1;
  logic [15:0] Instr0, Instr1;
  logic        Gnt0, Gnt1;
  logic        Done0, Done1;
  logic [15:0] Result;
  logic [4:0]  ResultFlags;
  logic [3:0]  RdestRegLoc, RsrcRegLoc;
  logic [15:0] Imm;
  logic        Imm_s;
  logic [3:0]  OpCode;
  logic        En;
  logic [15:0] RdestOut;
  logic [4:0]  Flags;

  modport slave (
    input  Req0, Req1, Instr0, Instr1, RdestOut, Flags,
    output Gnt0, Gnt1, Done0, Done1, Result, ResultFlags,
           RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode, En
  );

  modport master (
    output Req0, Req1, Instr0, Instr1, RdestOut, Flags,
    input  Gnt0, Gnt1, Done0, Done1, Result, ResultFlags,
           RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode, En
  );
endinterface

// File: rtl/regalu_sched_decode.sv
// regalu_instr_decode: combinational instruction decoder.
//   instr_i : 16-bit instruction
//   dec_o   : {rdest, rsrc(+valid), imm(+valid), imm_s, opcode}
// Class I[15:12]=0000 register form, 1000 shift (LSH, register form),
// anything else is immediate form with the class mapped as the opcode.
module regalu_instr_decode
  import regalu_pkg::*;
(
  input  logic [15:0] instr_i,
  output dec_t        dec_o
);
  logic [3:0] cls;
  assign cls = instr_i[15:12];

  always_comb begin
    dec_o       = '0;
    dec_o.rdest = instr_i[11:8];
    if (cls == CLS_REG || cls == CLS_SHIFT) begin
      dec_o.rsrc     = instr_i[3:0];
      dec_o.rsrc_vld = 1'b1;
      dec_o.imm_s    = 1'b0;
      dec_o.opcode   = (cls == CLS_SHIFT) ? OP_LSH : map_func(instr_i[7:4]);
    end else begin
      dec_o.opcode  = map_func(cls);
      dec_o.imm_s   = 1'b1;
      dec_o.imm_vld = 1'b1;
      // Arithmetic immediates are signed, logical ones unsigned.
      if (dec_o.opcode == OP_ADD || dec_o.opcode == OP_SUB || dec_o.opcode == OP_CMP)
        dec_o.imm = {{8{instr_i[7]}}, instr_i[7:0]};
      else
        dec_o.imm = {8'h00, instr_i[7:0]};
    end
  end
endmodule

// File: rtl/regalu_sched.sv
// regalu_sched: two-source scheduler for the shared RegFile_Alu datapath.
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-low reset
//   bus  : regalu_sched_if.slave (source handshake + datapath controls)
// Sequence: IDLE (grant) -> DECODE -> SETTLE x SETTLE_CYCLES -> WRITE -> RESP.
// All outputs are registered: Gnt is high the cycle after the capture edge,
// En the cycle after WRITE, Done/Result the cycle after RESP.
// Build option REGALU_SCHED_FIXED_PRIO_EN: source 0 always wins ties and the
// round-robin pointer is not built.
module regalu_sched
  import regalu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1  // legal 1..15
)(
  input logic           Clk,
  input logic           Rst,
  regalu_sched_if.slave bus
);
  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        src_q, src_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d, done_q, done_d;
  logic        en_q, en_d;
  logic [3:0]  rdest_q, rdest_d, rsrc_q, rsrc_d, op_q, op_d;
  logic [15:0] imm_q, imm_d, res_q, res_d;
  logic        imm_s_q, imm_s_d;
  logic [4:0]  flg_q, flg_d;
  logic        any_req, pick;
  dec_t        dec;

  assign any_req = bus.Req0 | bus.Req1;

`ifdef REGALU_SCHED_FIXED_PRIO_EN
  assign pick = ~bus.Req0;
`else
  // last_q = source granted most recently; resets to 1 so source 0 wins
  // the first tie.
  logic last_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                          last_q <= 1'b1;
    else if (state_q == IDLE && any_req) last_q <= pick;
  end
  assign pick = (bus.Req0 & bus.Req1) ? ~last_q : ~bus.Req0;
`endif

  regalu_instr_decode u_dec (.instr_i(instr_q), .dec_o(dec));

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    en_d    = 1'b0;
    rdest_d = rdest_q;
    rsrc_d  = rsrc_q;
    imm_d   = imm_q;
    imm_s_d = imm_s_q;
    op_d    = op_q;
    res_d   = res_q;
    flg_d   = flg_q;
    case (state_q)
      IDLE: if (any_req) begin
        src_d       = pick;
        instr_d     = pick ? bus.Instr1 : bus.Instr0;
        gnt_d[pick] = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        rdest_d = dec.rdest;
        if (dec.rsrc_vld) rsrc_d = dec.rsrc;
        if (dec.imm_vld)  imm_d  = dec.imm;
        imm_s_d = dec.imm_s;
        op_d    = dec.opcode;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = WRITE;
        else                                cnt_d   = cnt_q + 4'd1;
      end
      WRITE: begin
        en_d    = (op_q != OP_NOP);
        state_d = RESP;
      end
      RESP: begin
        res_d         = bus.RdestOut;
        flg_d         = bus.Flags;
        done_d[src_q] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      rdest_q <= '0;
      rsrc_q  <= '0;
      imm_q   <= '0;
      imm_s_q <= 1'b0;
      op_q    <= OP_NOP;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      rdest_q <= rdest_d;
      rsrc_q  <= rsrc_d;
      imm_q   <= imm_d;
      imm_s_q <= imm_s_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign bus.Gnt0        = gnt_q[0];
  assign bus.Gnt1        = gnt_q[1];
  assign bus.Done0       = done_q[0];
  assign bus.Done1       = done_q[1];
  assign bus.En          = en_q;
  assign bus.RdestRegLoc = rdest_q;
  assign bus.RsrcRegLoc  = rsrc_q;
  assign bus.Imm         = imm_q;
  assign bus.Imm_s       = imm_s_q;
  assign bus.OpCode      = op_q;
  assign bus.Result      = res_q;
  assign bus.ResultFlags = flg_q;
endmodule
